// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : ID-stage fields in, stage control bundle out
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       hold;

    logic       stall;
    logic [1:0] npc_ctrl;
    logic       ext_op;
    logic       illegal;
    logic       ex_alusrc;
    logic [3:0] ex_aluc;
    logic       ex_md_start;
    logic       ex_md_div;
    logic       ex_regwrite;
    logic       mem_regwrite;
    logic       wb_regwrite;
    logic [4:0] ex_waddr;
    logic [4:0] mem_waddr;
    logic [4:0] wb_waddr;
    logic       mem_memwrite;
    logic       wb_memtoreg;
    logic       wb_sel_pc;

    modport master (
        output op, funct, rs, rt, rd, hold,
        input  stall, npc_ctrl, ext_op, illegal, ex_alusrc, ex_aluc, ex_md_start,
               ex_md_div, ex_regwrite, mem_regwrite, wb_regwrite, ex_waddr,
               mem_waddr, wb_waddr, mem_memwrite, wb_memtoreg, wb_sel_pc
    );

    modport slave (
        input  op, funct, rs, rt, rd, hold,
        output stall, npc_ctrl, ext_op, illegal, ex_alusrc, ex_aluc, ex_md_start,
               ex_md_div, ex_regwrite, mem_regwrite, wb_regwrite, ex_waddr,
               mem_waddr, wb_waddr, mem_memwrite, wb_memtoreg, wb_sel_pc
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : pipelined MIPS main controller with load-use and MD-busy stalls
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_NOP   = 6'b000000;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_LUI  = 4'b0100;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_MFHI = 4'b1000;
    localparam logic [3:0] c_ALU_MFLO = 4'b1001;

    localparam logic [1:0] c_WSEL_RD  = 2'd0;
    localparam logic [1:0] c_WSEL_RT  = 2'd1;
    localparam logic [1:0] c_WSEL_31  = 2'd2;

    logic       w_regwrite, w_alusrc, w_md_start, w_md_div, w_memwrite, w_memtoreg;
    logic       w_sel_pc, w_ext_op, w_illegal, w_uses_rs, w_uses_rt, w_md_class;
    logic [1:0] w_wsel, w_npc;
    logic [3:0] w_aluc;
    logic [4:0] w_waddr;
    logic       w_load_use, w_md_hazard, w_stall, w_issue;

    logic             r_ex_alusrc, r_ex_md_start, r_ex_md_div, r_ex_regwrite;
    logic             r_ex_memwrite, r_ex_memtoreg, r_ex_sel_pc;
    logic [3:0]       r_ex_aluc;
    logic [4:0]       r_ex_waddr;
    logic             r_mem_regwrite, r_mem_memwrite, r_mem_memtoreg, r_mem_sel_pc;
    logic [4:0]       r_mem_waddr;
    logic             r_wb_regwrite, r_wb_memtoreg, r_wb_sel_pc;
    logic [4:0]       r_wb_waddr;
    logic [CNT_W-1:0] r_md_cnt;

    always_comb begin
        w_regwrite = 1'b0; w_wsel     = c_WSEL_RD; w_alusrc  = 1'b0; w_aluc    = c_ALU_AND;
        w_md_start = 1'b0; w_md_div   = 1'b0;      w_memwrite = 1'b0; w_memtoreg = 1'b0;
        w_sel_pc   = 1'b0; w_ext_op   = 1'b0;      w_npc     = 2'b00; w_illegal = 1'b0;
        w_uses_rs  = 1'b0; w_uses_rt  = 1'b0;      w_md_class = 1'b0;
        case (bus.op)
            c_OP_RTYPE: begin
                case (bus.funct)
                    c_FN_NOP:  w_illegal = 1'b0;
                    c_FN_ADDU: begin w_regwrite = 1'b1; w_aluc = c_ALU_ADD; w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
                    c_FN_SUBU: begin w_regwrite = 1'b1; w_aluc = c_ALU_SUB; w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
                    c_FN_AND:  begin w_regwrite = 1'b1; w_aluc = c_ALU_AND; w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
                    c_FN_OR:   begin w_regwrite = 1'b1; w_aluc = c_ALU_OR;  w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
                    c_FN_JR:   begin w_npc = 2'b11; w_uses_rs = 1'b1; end
                    c_FN_MULTU: begin
                        w_md_start = 1'b1; w_md_class = 1'b1; w_uses_rs = 1'b1; w_uses_rt = 1'b1;
                    end
                    c_FN_DIVU: begin
                        w_md_start = 1'b1; w_md_div = 1'b1; w_md_class = 1'b1;
                        w_uses_rs  = 1'b1; w_uses_rt = 1'b1;
                    end
                    c_FN_MFHI: begin w_regwrite = 1'b1; w_aluc = c_ALU_MFHI; w_md_class = 1'b1; end
                    c_FN_MFLO: begin w_regwrite = 1'b1; w_aluc = c_ALU_MFLO; w_md_class = 1'b1; end
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_OP_ORI:  begin w_regwrite = 1'b1; w_wsel = c_WSEL_RT; w_alusrc = 1'b1; w_aluc = c_ALU_OR;  w_uses_rs = 1'b1; end
            c_OP_ADDI: begin
                w_regwrite = 1'b1; w_wsel = c_WSEL_RT; w_alusrc = 1'b1; w_aluc = c_ALU_ADD;
                w_ext_op   = 1'b1; w_uses_rs = 1'b1;
            end
            c_OP_LUI:  begin w_regwrite = 1'b1; w_wsel = c_WSEL_RT; w_alusrc = 1'b1; w_aluc = c_ALU_LUI; end
            c_OP_LW:   begin
                w_regwrite = 1'b1; w_wsel = c_WSEL_RT; w_alusrc = 1'b1; w_aluc = c_ALU_ADD;
                w_memtoreg = 1'b1; w_ext_op = 1'b1; w_uses_rs = 1'b1;
            end
            c_OP_SW:   begin
                w_alusrc  = 1'b1; w_aluc = c_ALU_ADD; w_memwrite = 1'b1; w_ext_op = 1'b1;
                w_uses_rs = 1'b1; w_uses_rt = 1'b1;
            end
            c_OP_BEQ:  begin w_aluc = c_ALU_SUB; w_npc = 2'b10; w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
            c_OP_J:    w_npc = 2'b01;
            c_OP_JAL:  begin w_npc = 2'b01; w_regwrite = 1'b1; w_wsel = c_WSEL_31; w_sel_pc = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_waddr = 5'd0;
        if (w_regwrite) begin
            case (w_wsel)
                c_WSEL_RT: w_waddr = bus.rt;
                c_WSEL_31: w_waddr = 5'd31;
                default:   w_waddr = bus.rd;
            endcase
        end
    end

    assign w_load_use  = r_ex_memtoreg && (r_ex_waddr != 5'd0) &&
                         ((w_uses_rs && (r_ex_waddr == bus.rs)) || (w_uses_rt && (r_ex_waddr == bus.rt)));
    assign w_md_hazard = (r_md_cnt != '0) && w_md_class;
    assign w_stall     = (w_load_use || w_md_hazard) && !bus.hold;
    assign w_issue     = !bus.hold && !w_stall;

    // Reset also masks the ID decode so nothing is visible while rst_n is low.
    assign bus.stall    = w_stall && rst_n;
    assign bus.npc_ctrl = (w_issue && rst_n) ? w_npc : 2'b00;
    assign bus.ext_op   = w_ext_op && rst_n;
    assign bus.illegal  = w_illegal && w_issue && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_alusrc    <= 1'b0; r_ex_aluc     <= 4'd0; r_ex_md_start <= 1'b0; r_ex_md_div <= 1'b0;
            r_ex_regwrite  <= 1'b0; r_ex_waddr    <= 5'd0; r_ex_memwrite <= 1'b0;
            r_ex_memtoreg  <= 1'b0; r_ex_sel_pc   <= 1'b0;
            r_mem_regwrite <= 1'b0; r_mem_waddr   <= 5'd0; r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0; r_mem_sel_pc  <= 1'b0;
            r_wb_regwrite  <= 1'b0; r_wb_waddr    <= 5'd0; r_wb_memtoreg <= 1'b0; r_wb_sel_pc <= 1'b0;
        end else if (!bus.hold) begin
            r_ex_alusrc    <= w_issue && w_alusrc;
            r_ex_aluc      <= w_issue ? w_aluc : 4'd0;
            r_ex_md_start  <= w_issue && w_md_start;
            r_ex_md_div    <= w_issue && w_md_div;
            r_ex_regwrite  <= w_issue && w_regwrite;
            r_ex_waddr     <= w_issue ? w_waddr : 5'd0;
            r_ex_memwrite  <= w_issue && w_memwrite;
            r_ex_memtoreg  <= w_issue && w_memtoreg;
            r_ex_sel_pc    <= w_issue && w_sel_pc;
            r_mem_regwrite <= r_ex_regwrite;  r_mem_waddr  <= r_ex_waddr;  r_mem_memwrite <= r_ex_memwrite;
            r_mem_memtoreg <= r_ex_memtoreg;  r_mem_sel_pc <= r_ex_sel_pc;
            r_wb_regwrite  <= r_mem_regwrite; r_wb_waddr   <= r_mem_waddr;
            r_wb_memtoreg  <= r_mem_memtoreg; r_wb_sel_pc  <= r_mem_sel_pc;
        end
    end

    // The MD unit keeps counting through hold; it is not part of the freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (w_issue && w_md_start) begin
            r_md_cnt <= w_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    assign bus.ex_alusrc    = r_ex_alusrc;
    assign bus.ex_aluc      = r_ex_aluc;
    assign bus.ex_md_start  = r_ex_md_start;
    assign bus.ex_md_div    = r_ex_md_div;
    assign bus.ex_regwrite  = r_ex_regwrite;
    assign bus.ex_waddr     = r_ex_waddr;
    assign bus.mem_regwrite = r_mem_regwrite;
    assign bus.mem_waddr    = r_mem_waddr;
    assign bus.mem_memwrite = r_mem_memwrite;
    assign bus.wb_regwrite  = r_wb_regwrite;
    assign bus.wb_waddr     = r_wb_waddr;
    assign bus.wb_memtoreg  = r_wb_memtoreg;
    assign bus.wb_sel_pc    = r_wb_sel_pc;

    logic w_unused;
    assign w_unused = r_ex_sel_pc & r_mem_memtoreg & r_mem_sel_pc & r_ex_memwrite;
endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_JAL  = 6'b000011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ORI  = 6'b001101;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_MFHI = 6'b010000;
    localparam logic [5:0] c_FN_MFLO = 6'b010010;
    localparam logic [5:0] c_FN_MULT = 6'b011001;
    localparam logic [5:0] c_FN_ADDU = 6'b100001;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_stall;

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus_if.op = op; bus_if.funct = fn; bus_if.rs = rs; bus_if.rt = rt; bus_if.rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.hold = 1'b0;
        set_id(c_OP_LW, 6'd0, 5'd1, 5'd5, 5'd0);
        #12;
        check("reset_outs", {bus_if.stall, bus_if.npc_ctrl, bus_if.ext_op, bus_if.illegal,
                             bus_if.ex_alusrc, bus_if.ex_aluc, bus_if.ex_md_start, bus_if.ex_md_div,
                             bus_if.ex_regwrite, bus_if.mem_regwrite, bus_if.wb_regwrite,
                             bus_if.ex_waddr, bus_if.mem_waddr, bus_if.wb_waddr,
                             bus_if.mem_memwrite, bus_if.wb_memtoreg, bus_if.wb_sel_pc}, 32'd0);
        check("reset_mdcnt", dut.r_md_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        check("lw_ext_op", bus_if.ext_op, 1);

        // Load-use: LW r5 then ADDU r6,r5,r7
        tick();
        check("lw_ex", {bus_if.ex_regwrite, bus_if.ex_waddr, bus_if.ex_alusrc, bus_if.ex_aluc},
              {1'b1, 5'd5, 1'b1, 4'b0010});
        set_id(c_OP_R, c_FN_ADDU, 5'd5, 5'd7, 5'd6);
        #1;
        check("lu_stall", bus_if.stall, 1);
        tick();
        check("lu_bubble", {bus_if.ex_regwrite, bus_if.ex_waddr}, 32'd0);
        check("lu_mem", {bus_if.mem_regwrite, bus_if.mem_waddr}, {1'b1, 5'd5});
        check("lu_stall_end", bus_if.stall, 0);
        tick();
        check("addu_ex", {bus_if.ex_regwrite, bus_if.ex_waddr, bus_if.ex_alusrc, bus_if.ex_aluc},
              {1'b1, 5'd6, 1'b0, 4'b0010});
        check("lw_wb", {bus_if.wb_regwrite, bus_if.wb_memtoreg, bus_if.wb_waddr}, {1'b1, 1'b1, 5'd5});

        // Load into r0 never stalls
        set_id(c_OP_LW, 6'd0, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(c_OP_R, c_FN_ADDU, 5'd0, 5'd7, 5'd8);
        #1;
        check("r0_nostall", bus_if.stall, 0);
        tick();
        check("r0_addu_ex", bus_if.ex_waddr, 8);

        // MULTU then MFLO: 5 stall cycles
        set_id(c_OP_R, c_FN_MULT, 5'd2, 5'd3, 5'd0);
        tick();
        check("multu_ex", {bus_if.ex_md_start, bus_if.ex_md_div, bus_if.ex_regwrite, bus_if.ex_waddr},
              {1'b1, 1'b0, 1'b0, 5'd0});
        check("multu_cnt", dut.r_md_cnt, 5);
        set_id(c_OP_R, c_FN_MFLO, 5'd0, 5'd0, 5'd9);
        #1;
        n_stall = 0;
        while (bus_if.stall && n_stall < 20) begin
            n_stall++;
            tick();
            if (n_stall == 1) check("md_start_pulse", bus_if.ex_md_start, 0);
        end
        check("md_stall_len", n_stall, 5);
        tick();
        check("mflo_ex", {bus_if.ex_regwrite, bus_if.ex_waddr, bus_if.ex_aluc}, {1'b1, 5'd9, 4'b1001});

        // Hold for 3 cycles mid-pipeline
        set_id(c_OP_R, c_FN_MULT, 5'd2, 5'd3, 5'd0);
        tick();
        set_id(c_OP_ORI, 6'd0, 5'd1, 5'd10, 5'd0);
        tick();
        bus_if.hold = 1'b1;
        set_id(c_OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("hold_ctl", {bus_if.stall, bus_if.npc_ctrl}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_frozen", {bus_if.ex_regwrite, bus_if.ex_waddr, bus_if.ex_aluc, bus_if.ex_alusrc,
                                  bus_if.mem_regwrite, bus_if.wb_regwrite, bus_if.wb_waddr},
                  {1'b1, 5'd10, 4'b0001, 1'b1, 1'b0, 1'b1, 5'd9});
        end
        check("hold_mdcnt", dut.r_md_cnt, 1);
        bus_if.hold = 1'b0;
        #1;
        check("jal_npc", bus_if.npc_ctrl, 2'b01);
        tick();
        set_id(c_OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("jal_wb", {bus_if.wb_regwrite, bus_if.wb_waddr, bus_if.wb_sel_pc, bus_if.wb_memtoreg},
              {1'b1, 5'd31, 1'b1, 1'b0});

        // Illegal encoding
        set_id(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
        #1;
        check("illegal_on", bus_if.illegal, 1);
        tick();
        set_id(c_OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("illegal_off", bus_if.illegal, 0);
        check("illegal_ex", {bus_if.ex_regwrite, bus_if.ex_waddr, bus_if.ex_aluc, bus_if.ex_alusrc,
                             bus_if.ex_md_start}, 0);

        // BEQ / JR / SW
        set_id(c_OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        #1;
        check("beq_npc", {bus_if.npc_ctrl, bus_if.ext_op}, {2'b10, 1'b0});
        set_id(c_OP_R, c_FN_JR, 5'd4, 5'd0, 5'd0);
        #1;
        check("jr_npc", bus_if.npc_ctrl, 2'b11);
        set_id(c_OP_SW, 6'd0, 5'd1, 5'd2, 5'd0);
        #1;
        check("sw_ext", bus_if.ext_op, 1);
        tick();
        set_id(c_OP_R, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("sw_mem", {bus_if.mem_memwrite, bus_if.mem_regwrite, bus_if.mem_waddr}, {1'b1, 1'b0, 5'd0});

        // Reset during a load-use stall
        set_id(c_OP_LW, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(c_OP_R, c_FN_ADDU, 5'd5, 5'd7, 5'd6);
        #1;
        check("rst_lu_pre", bus_if.stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_lu_clear", {bus_if.stall, bus_if.ex_regwrite, bus_if.ex_waddr}, 0);
        rst_n = 1'b1;

        // Reset during an MD stall
        set_id(c_OP_R, c_FN_MULT, 5'd2, 5'd3, 5'd0);
        tick();
        set_id(c_OP_R, c_FN_MFHI, 5'd0, 5'd0, 5'd11);
        #1;
        check("rst_md_pre", bus_if.stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_md_clear", {bus_if.stall, bus_if.ex_md_start}, 0);
        check("rst_md_cnt", dut.r_md_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("rst_md_after", bus_if.stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
